// File: rtl/brush_painter.sv
// rtl/brush_painter.sv - paint command expander driving single-pixel writes into the pixel store
module brush_painter #(
    parameter int         COORD_BITS  = 7,
    parameter int         HOLD_CYCLES = 2,
    parameter logic [2:0] ERASE_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [7:0] cmdX,
    input  logic [7:0] cmdY,
    input  logic [2:0] cmdColor,
    input  logic [1:0] cmdSize,
    input  logic       cmdClear,
    output logic [7:0] wx,
    output logic [7:0] wy,
    output logic [2:0] newColor,
    output logic       brush,
    output logic       busy
);

    localparam int PW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int AW = 2 * COORD_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state_q;
    logic [7:0]    org_x_q;
    logic [7:0]    org_y_q;
    logic [2:0]    color_q;
    logic [1:0]    size_q;
    logic [1:0]    dx_q;
    logic [1:0]    dy_q;
    logic [AW-1:0] addr_q;
    logic [PW-1:0] phase_q;
    logic [7:0]    wx_q;
    logic [7:0]    wy_q;
    logic [2:0]    new_color_q;
    logic          brush_q;

    logic [1:0]    dx_d;
    logic [1:0]    dy_d;
    logic [AW-1:0] addr_d;
    logic          hold_done;
    logic          last_pixel;
    logic          last_addr;
    logic [8:0]    sum_x;
    logic [8:0]    sum_y;
    logic          sum_in_canvas;
    logic          start_in_canvas;
    logic [7:0]    sum_wx;
    logic [7:0]    sum_wy;
    logic [7:0]    start_wx;
    logic [7:0]    start_wy;
    logic [7:0]    addr_wx;
    logic [7:0]    addr_wy;

    // Next raster offset (dx fastest) and the 9-bit target it lands on; the
    // bits above the canvas width decide clipping, the low bits go out as-is.
    always_comb begin
        hold_done  = (phase_q == PW'(HOLD_CYCLES - 1));
        last_pixel = (dx_q == size_q) && (dy_q == size_q);
        last_addr  = &addr_q;
        addr_d     = addr_q + AW'(1);
        dx_d       = dx_q + 2'd1;
        dy_d       = dy_q;
        if (dx_q == size_q) begin
            dx_d = 2'd0;
            dy_d = dy_q + 2'd1;
        end
        sum_x = {1'b0, org_x_q} + {7'd0, dx_d};
        sum_y = {1'b0, org_y_q} + {7'd0, dy_d};
        sum_in_canvas   = ((sum_x >> COORD_BITS) == 9'd0) && ((sum_y >> COORD_BITS) == 9'd0);
        start_in_canvas = (({1'b0, cmdX} >> COORD_BITS) == 9'd0) &&
                          (({1'b0, cmdY} >> COORD_BITS) == 9'd0);
        sum_wx   = 8'(sum_x[COORD_BITS-1:0]);
        sum_wy   = 8'(sum_y[COORD_BITS-1:0]);
        start_wx = 8'(cmdX[COORD_BITS-1:0]);
        start_wy = 8'(cmdY[COORD_BITS-1:0]);
        addr_wx  = 8'(addr_d[COORD_BITS-1:0]);
        addr_wy  = 8'(addr_d[AW-1:COORD_BITS]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            org_x_q     <= 8'd0;
            org_y_q     <= 8'd0;
            color_q     <= 3'd0;
            size_q      <= 2'd0;
            dx_q        <= 2'd0;
            dy_q        <= 2'd0;
            addr_q      <= '0;
            phase_q     <= '0;
            wx_q        <= 8'd0;
            wy_q        <= 8'd0;
            new_color_q <= 3'd0;
            brush_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    brush_q <= 1'b0;
                    if (cmdValid) begin
                        org_x_q <= cmdX;
                        org_y_q <= cmdY;
                        color_q <= cmdColor;
                        size_q  <= cmdSize;
                        dx_q    <= 2'd0;
                        dy_q    <= 2'd0;
                        addr_q  <= '0;
                        phase_q <= '0;
                        if (cmdClear) begin
                            state_q     <= CLEAR;
                            wx_q        <= 8'd0;
                            wy_q        <= 8'd0;
                            new_color_q <= ERASE_COLOR;
                            brush_q     <= 1'b1;
                        end else begin
                            state_q     <= PAINT;
                            wx_q        <= start_wx;
                            wy_q        <= start_wy;
                            new_color_q <= cmdColor;
                            brush_q     <= start_in_canvas;
                        end
                    end
                end
                PAINT: begin
                    if (!hold_done) begin
                        phase_q <= phase_q + PW'(1);
                    end else begin
                        phase_q <= '0;
                        if (last_pixel) begin
                            state_q <= IDLE;
                            brush_q <= 1'b0;
                            dx_q    <= 2'd0;
                            dy_q    <= 2'd0;
                        end else begin
                            dx_q        <= dx_d;
                            dy_q        <= dy_d;
                            wx_q        <= sum_wx;
                            wy_q        <= sum_wy;
                            new_color_q <= color_q;
                            brush_q     <= sum_in_canvas;
                        end
                    end
                end
                CLEAR: begin
                    if (!hold_done) begin
                        phase_q <= phase_q + PW'(1);
                    end else begin
                        phase_q <= '0;
                        if (last_addr) begin
                            state_q <= IDLE;
                            brush_q <= 1'b0;
                            addr_q  <= '0;
                        end else begin
                            addr_q      <= addr_d;
                            wx_q        <= addr_wx;
                            wy_q        <= addr_wy;
                            new_color_q <= ERASE_COLOR;
                            brush_q     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    brush_q <= 1'b0;
                    phase_q <= '0;
                end
            endcase
        end
    end

    assign cmdReady = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign wx       = wx_q;
    assign wy       = wy_q;
    assign newColor = new_color_q;
    assign brush    = brush_q;

endmodule
